// File: rtl/alarm_pkg.sv
// Shared encodings for the alarm display sequencer: FSM states, display colour
// codes, alarm cause and debounced-input lane indices.
package alarm_pkg;
  localparam int TIMER_W = 8;
  localparam int NUM_IN  = 5;

  localparam int IDX_ARM  = 0;
  localparam int IDX_DOOR = 1;
  localparam int IDX_WIN  = 2;
  localparam int IDX_MOT  = 3;
  localparam int IDX_TEMP = 4;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    DM_IDLE      = 3'd0,
    DM_TEMP      = 3'd1,
    DM_INTRUSION = 3'd2,
    DM_WINDOW    = 3'd3,
    DM_ARMED     = 3'd4,
    DM_PENDING   = 3'd5
  } mode_e;

  typedef enum logic {
    CAUSE_INTRUSION = 1'b0,
    CAUSE_WINDOW    = 1'b1
  } cause_e;

  function automatic mode_e cause_mode(input cause_e c);
    return (c == CAUSE_WINDOW) ? DM_WINDOW : DM_INTRUSION;
  endfunction

  function automatic logic is_blinking(input state_e s);
    return (s == ST_EXIT) || (s == ST_ENTRY) || (s == ST_ALARM);
  endfunction
endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchronizer followed by a frame-tick debounce filter: the filtered
// value only follows the input after DEBOUNCE_FRAMES consecutive disagreeing ticks.
module input_debouncer #(
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_filt
);
  logic       r_meta;
  logic       r_sync;
  logic       r_filt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (i_tick) begin
        if (r_sync != r_filt) begin
          if (w_cnt_inc == 4'(DEBOUNCE_FRAMES)) begin
            r_filt <= r_sync;
            r_cnt  <= '0;
          end else begin
            r_cnt  <= w_cnt_inc;
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end
  end

  assign o_filt = r_filt;
endmodule

// File: rtl/alarm_sequencer.sv
// Arm/exit/entry/alarm controller for the alarm VGA display. State reacts every
// clock; the display colour code only changes on frame_tick so frames never tear.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int EXIT_FRAMES     = 60,
  parameter int ENTRY_FRAMES    = 30,
  parameter int BLINK_FRAMES    = 15,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm_in,
  input  logic               door_in,
  input  logic               window_in,
  input  logic               motion_in,
  input  logic               temp_in,
  input  logic               clear_in,
  input  logic               frame_tick,
  output logic [2:0]         display_mode,
  output logic [2:0]         state,
  output logic               alarm_active,
  output logic [TIMER_W-1:0] delay_remaining
);
  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_filt;
  logic              w_arm, w_door, w_win, w_mot, w_temp;

  logic              r_clr_meta, r_clr_sync;

  state_e             r_state, w_state_nx;
  logic [TIMER_W-1:0] r_timer, w_timer_nx;
  cause_e             r_cause, w_cause_nx;
  logic               r_blink, w_blink_nx;
  logic [TIMER_W-1:0] r_bcnt,  w_bcnt_nx;
  mode_e              r_mode,  w_mode_nx;

  assign w_raw = {temp_in, motion_in, window_in, door_in, arm_in};

  input_debouncer #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb [NUM_IN-1:0] (
    .clk    (clk),
    .reset  (reset),
    .i_raw  (w_raw),
    .i_tick (frame_tick),
    .o_filt (w_filt)
  );

  assign w_arm  = w_filt[IDX_ARM];
  assign w_door = w_filt[IDX_DOOR];
  assign w_win  = w_filt[IDX_WIN];
  assign w_mot  = w_filt[IDX_MOT];
  assign w_temp = w_filt[IDX_TEMP];

  // Clear must act quickly, so it is synchronized but never debounced.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_meta <= 1'b0;
      r_clr_sync <= 1'b0;
    end else begin
      r_clr_meta <= clear_in;
      r_clr_sync <= r_clr_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_DISARMED;
      r_timer <= '0;
      r_cause <= CAUSE_INTRUSION;
      r_blink <= 1'b1;
      r_bcnt  <= '0;
      r_mode  <= DM_IDLE;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_cause <= w_cause_nx;
      r_blink <= w_blink_nx;
      r_bcnt  <= w_bcnt_nx;
      if (frame_tick) r_mode <= w_mode_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_cause_nx = r_cause;
    if (r_clr_sync) begin
      w_state_nx = ST_DISARMED;
    end else if (w_win && (r_state != ST_ALARM)) begin
      w_state_nx = ST_ALARM;
      w_cause_nx = CAUSE_WINDOW;
    end else if (!w_arm && (r_state == ST_EXIT || r_state == ST_ARMED ||
                            r_state == ST_ENTRY)) begin
      w_state_nx = ST_DISARMED;
    end else begin
      case (r_state)
        ST_DISARMED: if (w_arm) begin
          w_state_nx = ST_EXIT;
          w_timer_nx = TIMER_W'(EXIT_FRAMES);
        end
        ST_EXIT: if (frame_tick) begin
          if (r_timer == TIMER_W'(1))   w_state_nx = ST_ARMED;
          else if (r_timer != '0)       w_timer_nx = r_timer - TIMER_W'(1);
        end
        ST_ARMED: if (w_door && w_mot) begin
          w_state_nx = ST_ENTRY;
          w_timer_nx = TIMER_W'(ENTRY_FRAMES);
        end
        ST_ENTRY: if (frame_tick) begin
          if (r_timer == TIMER_W'(1)) begin
            w_state_nx = ST_ALARM;
            w_cause_nx = CAUSE_INTRUSION;
          end else if (r_timer != '0) begin
            w_timer_nx = r_timer - TIMER_W'(1);
          end
        end
        default: ;
      endcase
    end
    // Only the countdown states ever hold a non-zero timer.
    if (!(w_state_nx == ST_EXIT || w_state_nx == ST_ENTRY)) w_timer_nx = '0;
  end

  always_comb begin
    w_blink_nx = r_blink;
    w_bcnt_nx  = r_bcnt;
    if (!is_blinking(w_state_nx) || (w_state_nx != r_state)) begin
      w_blink_nx = 1'b1;
      w_bcnt_nx  = '0;
    end else if (frame_tick) begin
      if (r_bcnt == TIMER_W'(BLINK_FRAMES - 1)) begin
        w_blink_nx = ~r_blink;
        w_bcnt_nx  = '0;
      end else begin
        w_bcnt_nx  = r_bcnt + TIMER_W'(1);
      end
    end
  end

  // Uses pre-tick state so a transition on the tick shows up one frame later.
  always_comb begin
    w_mode_nx = DM_IDLE;
    if (r_clr_sync) begin
      w_mode_nx = DM_IDLE;
    end else if (w_temp) begin
      w_mode_nx = DM_TEMP;
    end else begin
      case (r_state)
        ST_ALARM:          w_mode_nx = r_blink ? cause_mode(r_cause) : DM_IDLE;
        ST_EXIT, ST_ENTRY: w_mode_nx = r_blink ? DM_PENDING : DM_IDLE;
        ST_ARMED:          w_mode_nx = DM_ARMED;
        default:           w_mode_nx = DM_IDLE;
      endcase
    end
  end

  assign display_mode    = r_mode;
  assign state           = r_state;
  assign alarm_active    = (r_state == ST_ALARM);
  assign delay_remaining = r_timer;
endmodule
